// File: rtl/gouram_trace_collector_if.sv
// gouram_trace_collector_if: trace-producer and record-consumer handshakes of the collector.
interface gouram_trace_collector_if #(
    parameter int NUM_CHANNELS    = 2,
    parameter int RECORD_WIDTH    = 128,
    parameter int TIMESTAMP_WIDTH = 32
);
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    logic [NUM_CHANNELS-1:0]                       trace_valid_i;
    logic [NUM_CHANNELS*RECORD_WIDTH-1:0]          trace_data_i;
    logic [NUM_CHANNELS-1:0]                       trace_ready_o;
    logic                                          out_valid_o;
    logic                                          out_ready_i;
    logic [CH_W+TIMESTAMP_WIDTH+RECORD_WIDTH-1:0]  out_data_o;
    modport master (
        output trace_valid_i, trace_data_i, out_ready_i,
        input  trace_ready_o, out_valid_o, out_data_o
    );
    modport slave (
        input  trace_valid_i, trace_data_i, out_ready_i,
        output trace_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/gouram_trace_collector.sv
// gouram_trace_collector: round-robin merge of N trace channels into a timestamped
// first-word-fall-through FIFO with flush and almost-full lock.
module gouram_trace_collector #(
    parameter int NUM_CHANNELS      = 2,
    parameter int RECORD_WIDTH      = 128,
    parameter int FIFO_DEPTH        = 16,
    parameter int TIMESTAMP_WIDTH   = 32,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    gouram_trace_collector_if.slave      bus,
    input  logic                         flush_i,
    output logic [$clog2(FIFO_DEPTH):0]  fill_level_o,
    output logic                         lock,
    output logic [TIMESTAMP_WIDTH-1:0]   counter_o,
    output logic [31:0]                  accepted_count_o
);
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int OW   = CH_W + TIMESTAMP_WIDTH + RECORD_WIDTH;

    logic [OW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr, next_rd;
    logic [AW:0]     after_rd, next_fill;
    logic [CH_W-1:0] last_grant, gnt_id;
    logic            gnt, can_write, do_rd;
    logic [OW-1:0]   wdata, next_head;

    // A read in the flush cycle is void; a full FIFO still accepts when its head pops.
    assign do_rd     = bus.out_valid_o & bus.out_ready_i & ~flush_i;
    assign can_write = rst_n & ~flush_i &
                       ((int'(fill_level_o) < FIFO_DEPTH) | (bus.out_valid_o & bus.out_ready_i));

    always_comb begin
        gnt    = 1'b0;
        gnt_id = '0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            logic [CH_W-1:0] c;
            c = CH_W'((int'(last_grant) + i) % NUM_CHANNELS);
            if (can_write && !gnt && bus.trace_valid_i[c]) begin
                gnt    = 1'b1;
                gnt_id = c;
            end
        end
    end

    assign bus.trace_ready_o = gnt ? (NUM_CHANNELS'(1) << gnt_id) : '0;
    assign wdata     = {gnt_id, counter_o, bus.trace_data_i[int'(gnt_id)*RECORD_WIDTH +: RECORD_WIDTH]};
    assign after_rd  = fill_level_o - (AW+1)'(do_rd);
    assign next_fill = flush_i ? '0 : after_rd + (AW+1)'(gnt);
    assign next_rd   = rd_ptr + AW'(do_rd);
    // The incoming record becomes the head when nothing older survives this cycle.
    assign next_head = (gnt && after_rd == '0) ? wdata : mem[next_rd];

    always_ff @(posedge clk) begin
        if (gnt) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            fill_level_o     <= '0;
            lock             <= 1'b0;
            counter_o        <= '0;
            accepted_count_o <= '0;
            last_grant       <= CH_W'(NUM_CHANNELS - 1);
            bus.out_valid_o  <= 1'b0;
            bus.out_data_o   <= '0;
        end else begin
            counter_o        <= counter_o + TIMESTAMP_WIDTH'(1);
            accepted_count_o <= accepted_count_o + 32'(gnt);
            fill_level_o     <= next_fill;
            lock             <= int'(next_fill) >= ALMOST_FULL_LEVEL;
            bus.out_valid_o  <= next_fill != '0;
            rd_ptr           <= flush_i ? '0 : next_rd;
            wr_ptr           <= flush_i ? '0 : wr_ptr + AW'(gnt);
            if (next_fill != '0) bus.out_data_o <= next_head;
            if (gnt) last_grant <= gnt_id;
        end
    end
endmodule

// File: tb/tb_gouram_trace_collector.sv
// tb_gouram_trace_collector: randomized and directed stimulus against a queue-based
// reference model; a separate monitor pops the scoreboard on every output transfer.
module tb_gouram_trace_collector;
    localparam int N     = 2;
    localparam int RW    = 128;
    localparam int DEPTH = 16;
    localparam int TW    = 32;
    localparam int AF    = 12;
    localparam int CH_W  = 1;
    localparam int OW    = CH_W + TW + RW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic [4:0]    fill;
    logic          lock;
    logic [TW-1:0] counter;
    logic [31:0]   acc_cnt;

    gouram_trace_collector_if #(.NUM_CHANNELS(N), .RECORD_WIDTH(RW), .TIMESTAMP_WIDTH(TW)) bus ();

    gouram_trace_collector #(
        .NUM_CHANNELS(N), .RECORD_WIDTH(RW), .FIFO_DEPTH(DEPTH),
        .TIMESTAMP_WIDTH(TW), .ALMOST_FULL_LEVEL(AF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush_i(flush_i),
        .fill_level_o(fill), .lock(lock), .counter_o(counter), .accepted_count_o(acc_cnt)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [OW-1:0] sb[$];
    logic [OW-1:0] held = '0;
    logic [N-1:0]  pv = '0;
    logic [RW-1:0] pd [N];
    logic [TW-1:0] ts = '0;
    logic [31:0]   acc = '0;
    int            lg = N - 1;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rnd_rec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic reset_checks();
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_out_data", bus.out_data_o, 0);
        chk("rst_fill", fill, 0);
        chk("rst_lock", lock, 0);
        chk("rst_counter", counter, 0);
        chk("rst_accepted", acc_cnt, 0);
        chk("rst_ready", bus.trace_ready_o, 0);
    endtask

    // Producers hold valid/data until the model sees them accepted.
    task automatic step(input logic [N-1:0] en, input logic ordy, input logic fl, input int pct);
        int   g;
        logic cw;
        for (int k = 0; k < N; k++)
            if (!pv[k] && en[k] && $urandom_range(0, 99) < pct) begin
                pv[k] = 1'b1;
                pd[k] = rnd_rec();
            end
        bus.trace_valid_i = pv;
        for (int k = 0; k < N; k++) bus.trace_data_i[k*RW +: RW] = pd[k];
        bus.out_ready_i = ordy;
        flush_i = fl;
        #3;
        chk("counter", counter, ts);
        chk("accepted", acc_cnt, acc);
        chk("fill", fill, sb.size());
        chk("lock", lock, sb.size() >= AF);
        chk("out_valid", bus.out_valid_o, sb.size() != 0);
        if (sb.size() != 0) held = sb[0];
        chk("head", bus.out_data_o, held);
        cw = !fl && (sb.size() < DEPTH || (sb.size() != 0 && ordy));
        g = -1;
        for (int i = 1; i <= N; i++)
            if (cw && g < 0 && pv[(lg + i) % N]) g = (lg + i) % N;
        chk("ready", bus.trace_ready_o, g < 0 ? 0 : (1 << g));
        if (fl) sb.delete();
        else if (g >= 0) begin
            sb.push_back({CH_W'(g), ts, pd[g]});
            lg = g;
            acc++;
            pv[g] = 1'b0;
        end
        @(posedge clk);
        ts++;
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && bus.out_valid_o && bus.out_ready_i && !flush_i) begin
            chk("sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("out_data", bus.out_data_o, sb.pop_front());
        end
    end

    initial begin
        bus.trace_valid_i = '0;
        bus.trace_data_i  = '0;
        bus.out_ready_i   = 1'b0;
        for (int k = 0; k < N; k++) pd[k] = '0;
        #2;
        reset_checks();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step('0, 1'b1, 1'b0, 0);
        pv[0] = 1'b1;
        pd[0] = RW'(8'hA5);
        step('0, 1'b1, 1'b0, 0);
        repeat (12) step('1, 1'b1, 1'b0, 100);
        repeat (6) step('0, 1'b1, 1'b0, 0);
        repeat (20) step(2'b10, 1'b0, 1'b0, 100);
        repeat (4) step(2'b01, 1'b1, 1'b0, 100);
        repeat (25) step('0, 1'b1, 1'b0, 0);
        repeat (5) step(2'b01, 1'b0, 1'b0, 100);
        step(2'b01, 1'b1, 1'b1, 100);
        step(2'b01, 1'b0, 1'b0, 100);
        for (int i = 0; i < 20 && sb.size() < 7; i++) step(2'b01, 1'b0, 1'b0, 100);
        #2 rst_n = 1'b0;
        #1;
        reset_checks();
        sb.delete();
        lg   = N - 1;
        ts   = '0;
        acc  = '0;
        held = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step('1, 1'b1, 1'b0, 100);
        repeat (400) step(N'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 29) == 0, 60);
        repeat (30) step('0, 1'b1, 1'b0, 0);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gouram_trace_collector.md
Name: gouram_trace_collector

Overview:
- Multi-channel trace record collector that merges N Gouram trace streams into one buffered, timestamped output stream for the debug/offload path.
- The previous tracer produced a single 128-bit record plus a capture-enable pulse, with no backpressure.
- This block adds per-channel valid/ready handshakes, round-robin arbitration, a parametrised FIFO, cycle timestamps, channel tagging, flush, and almost-full "lock" signalling.

Parameters:
- NUM_CHANNELS, 2, number of trace input channels (1..8).
- RECORD_WIDTH, 128, bits per trace record.
- FIFO_DEPTH, 16, output FIFO entries (power of two, >=2).
- TIMESTAMP_WIDTH, 32, width of free-running cycle counter.
- ALMOST_FULL_LEVEL, 12, fill level at or above which lock is asserted.
- CH_W (derived), max(1, $clog2(NUM_CHANNELS)), channel id width.

Ports:
- clk  input  1  clock, single domain.
- rst_n  input  1  asynchronous active-low reset.
- trace_valid_i  input  NUM_CHANNELS  per-channel record valid.
- trace_data_i  input  NUM_CHANNELS*RECORD_WIDTH  records; channel k occupies bits [k*RECORD_WIDTH +: RECORD_WIDTH].
- trace_ready_o  output  NUM_CHANNELS  per-channel accept (one-hot or zero).
- flush_i  input  1  synchronous FIFO clear.
- out_valid_o  output  1  FIFO head valid.
- out_ready_i  input  1  consumer accept.
- out_data_o  output  CH_W+TIMESTAMP_WIDTH+RECORD_WIDTH  {channel id, timestamp, record}.
- fill_level_o  output  $clog2(FIFO_DEPTH)+1  current entry count.
- lock  output  1  fill_level_o >= ALMOST_FULL_LEVEL.
- counter_o  output  TIMESTAMP_WIDTH  free-running timestamp.
- accepted_count_o  output  32  total records accepted since reset; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; out_valid_o=0, out_data_o=0, fill_level_o=0, lock=0, counter_o=0, accepted_count_o=0, trace_ready_o=0.
  - RR pointer last_grant=NUM_CHANNELS-1, so channel 0 has first priority.
  - Reset mid-transfer discards all buffered records.
- Timestamp: counter_o increments by 1 every cycle after reset and wraps from all-ones to 0.
- Handshake:
  - A channel transfer occurs when trace_valid_i[k] & trace_ready_o[k].
  - A producer holds data and valid stable until accepted.
  - Output transfer occurs when out_valid_o & out_ready_i.
- Arbitration (combinational within the cycle):
  - can_write = !flush_i & (fill<FIFO_DEPTH | (out_valid_o & out_ready_i)).
  - If can_write, grant the first valid channel searching last_grant+1, +2, ... modulo NUM_CHANNELS.
  - trace_ready_o is one-hot at the granted channel, else 0.
  - On a grant, last_grant <= granted channel; with no grant, last_grant holds.
- Write:
  - The FIFO entry is {granted id, counter_o value in the accept cycle, record}.
  - The record is visible at out_data_o no earlier than the next cycle (first-word fall-through, 1-cycle write latency).
  - accepted_count_o increments by 1 per accepted record.
- Read:
  - The head is presented while fill>0; it pops on an output transfer.
  - Simultaneous read and write leaves fill unchanged; this includes the full case, where the write is permitted.
- Flush:
  - flush_i=1 for one cycle sets fill=0 and out_valid_o=0 at the next edge.
  - No channel is accepted in the flush cycle; any concurrent output read is void.
  - counter_o and accepted_count_o are not cleared.
- Full: with fill=FIFO_DEPTH and no read, all trace_ready_o=0; no record is ever dropped or overwritten.
- Empty: out_valid_o=0 and out_data_o holds its last value; out_ready_i is ignored.
- lock: registered and updated from the next-state fill each cycle. There is no hysteresis.
- NUM_CHANNELS=1: the arbiter degenerates to pass-through and the channel id field is a constant 0.

Test Plan:
- Reset, then ch0 valid with data 0xA5 (zero-extended) at counter 3, out_ready_i=1 -> trace_ready_o=2'b01 at cycle 3; next cycle out_valid_o=1, out_data_o={0, 32'd3, 0xA5}; accepted_count_o=1.
- Both channels valid continuously, out_ready_i=1 -> grants alternate ch0, ch1, ch0, ...; output ids 0,1,0,1; timestamps strictly increasing by 1.
- out_ready_i=0, ch1 valid for 20 cycles, depth 16:
  - 16 accepted, then trace_ready_o=0.
  - lock rises on the cycle after the 12th accept.
  - fill_level_o=16.
  - Data is held stable while stalled.
- FIFO full, then out_ready_i=1 with ch0 valid -> read and write in the same cycle; fill stays 16; order preserved (oldest record out first).
- 5 entries buffered, assert flush_i with ch0 valid -> next cycle fill=0, out_valid_o=0; ch0 not accepted in the flush cycle, accepted on the following cycle.
- Assert rst_n=0 asynchronously mid-stream with 7 entries buffered -> outputs go to reset values immediately without a clock edge; after release, counter_o restarts at 0 and channel 0 is granted first.
